// File: rtl/out_port_receiver.sv
// ---------------------------------------------------------------------------
// out_port_receiver
//
// Consumer end of the processor OUT-port interface. Every word the core
// strobes out through outSignalEn/outPortData is captured into a small
// show-ahead FIFO and handed to an external device over a valid/ready
// handshake. This decouples single-cycle OUT strobes from a slower consumer.
// Occupancy, a sticky overflow flag and a saturating dropped-word counter are
// reported so software can tell when the consumer fell behind.
//
// Ports
//   clk            rising-edge clock shared with the processor
//   reset          synchronous, active-high; discards FIFO contents
//   outSignalEn    OUT strobe from the core, one word per high cycle
//   outPortData    OUT data, valid when outSignalEn=1
//   consumerReady  consumer accepts the head word this cycle
//   overflowClear  clears overflowFlag and dropCount
//   consumerData   head-of-FIFO word, 0 when empty
//   consumerValid  FIFO holds at least one word
//   fifoCount      entries held, 0..DEPTH
//   fifoFull       fifoCount == DEPTH
//   overflowFlag   sticky, set whenever a word is dropped
//   dropCount      words dropped, saturates at all-ones
// ---------------------------------------------------------------------------
module out_port_receiver #(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int DATA_W = 16,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              outSignalEn,
  input  logic [DATA_W-1:0] outPortData,
  input  logic              consumerReady,
  input  logic              overflowClear,
  output logic [DATA_W-1:0] consumerData,
  output logic              consumerValid,
  output logic [AW:0]       fifoCount,
  output logic              fifoFull,
  output logic              overflowFlag,
  output logic [DROP_W-1:0] dropCount
);

  localparam logic [AW:0]       FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX   = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic valid;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Status comes purely from registered state, so no input reaches an output
  // combinationally.
  assign valid = (count_q != '0);
  assign full  = (count_q == FULL_COUNT);

  // A push into a full FIFO is still accepted when the head leaves in the
  // same cycle; otherwise a strobe into a full FIFO is a drop.
  assign pop  = valid & consumerReady;
  assign push = outSignalEn & (~full | pop);
  assign drop = outSignalEn & full & ~pop;

  // Next-state logic for pointers, occupancy, storage and overflow tracking.
  // When full with push and pop together, wr_ptr equals rd_ptr: the head is
  // read out this cycle and overwritten at the same edge, which is safe.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (push) begin
      mem_d[wr_ptr_q] = outPortData;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end

    // A drop in the same cycle as a clear wins, so the clear restarts the
    // count at one rather than zero.
    if (drop) begin
      overflow_d = 1'b1;
      if (overflowClear) begin
        drop_d = DROP_W'(1);
      end else if (drop_q != DROP_MAX) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (overflowClear) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end
  end

  // Control state, reset synchronously; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is never reset; resetting the pointers and count is enough to
  // discard the contents.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Show-ahead head word, forced to zero while empty.
  assign consumerData  = valid ? mem_q[rd_ptr_q] : '0;
  assign consumerValid = valid;
  assign fifoCount     = count_q;
  assign fifoFull      = full;
  assign overflowFlag  = overflow_q;
  assign dropCount     = drop_q;

endmodule

// File: tb/tb_out_port_receiver.sv
// ---------------------------------------------------------------------------
// tb_out_port_receiver
//
// Directed bench for out_port_receiver with DEPTH=8, DATA_W=16, DROP_W=8.
// Inputs change 1 time unit after a rising edge and outputs are sampled in
// that same window, so every check observes settled post-edge state.
// ---------------------------------------------------------------------------
module tb_out_port_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        outSignalEn;
  logic [15:0] outPortData;
  logic        consumerReady;
  logic        overflowClear;
  logic [15:0] consumerData;
  logic        consumerValid;
  logic [3:0]  fifoCount;
  logic        fifoFull;
  logic        overflowFlag;
  logic [7:0]  dropCount;

  int vectorCount = 0;
  int missCount   = 0;

  out_port_receiver #(
    .DEPTH (8),
    .AW    (3),
    .DATA_W(16),
    .DROP_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .outSignalEn  (outSignalEn),
    .outPortData  (outPortData),
    .consumerReady(consumerReady),
    .overflowClear(overflowClear),
    .consumerData (consumerData),
    .consumerValid(consumerValid),
    .fifoCount    (fifoCount),
    .fifoFull     (fifoFull),
    .overflowFlag (overflowFlag),
    .dropCount    (dropCount)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count it.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic rst, input logic en,
                               input logic [15:0] data, input logic rdy,
                               input logic clr);
    reset         = rst;
    outSignalEn   = en;
    outPortData   = data;
    consumerReady = rdy;
    overflowClear = clr;
    @(posedge clk);
    #1;
  endtask

  // Full set of reset-value checks.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "Count"}, 32'(fifoCount), 32'd0);
    checkOutput({tag, "Valid"}, 32'(consumerValid), 32'd0);
    checkOutput({tag, "Data"},  32'(consumerData), 32'd0);
    checkOutput({tag, "Full"},  32'(fifoFull), 32'd0);
    checkOutput({tag, "Flag"},  32'(overflowFlag), 32'd0);
    checkOutput({tag, "Drops"}, 32'(dropCount), 32'd0);
  endtask

  initial begin
    int        model[$];
    int        sent;
    int        got;
    bit        popNow;
    bit        rdyNow;
    bit        enNow;
    logic [15:0] word;

    reset = 1'b1; outSignalEn = 1'b0; outPortData = '0;
    consumerReady = 1'b0; overflowClear = 1'b0;
    #1;

    // 1: reset held two cycles while the core keeps strobing.
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);
    checkResetState("reset");

    // 2: single word, held while not ready, then consumed.
    applyStimulus(1'b0, 1'b1, 16'hA5A5, 1'b0, 1'b0);
    checkOutput("singleValid", 32'(consumerValid), 32'd1);
    checkOutput("singleData",  32'(consumerData), 32'hA5A5);
    checkOutput("singleCount", 32'(fifoCount), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    checkOutput("singleHold",  32'(consumerData), 32'hA5A5);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("singlePopValid", 32'(consumerValid), 32'd0);
    checkOutput("singlePopData",  32'(consumerData), 32'd0);
    // Ready while empty must not disturb anything.
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    checkOutput("emptyReadyCount", 32'(fifoCount), 32'd0);

    // 3: fill with words 1..9; the ninth is dropped.
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
    end
    checkOutput("fillFull",  32'(fifoFull), 32'd1);
    checkOutput("fillCount", 32'(fifoCount), 32'd8);
    checkOutput("fillHead",  32'(consumerData), 32'd1);
    checkOutput("fillFlag",  32'(overflowFlag), 32'd1);
    checkOutput("fillDrops", 32'(dropCount), 32'd1);

    // 4: full with push and pop together; no drop, count stays at 8.
    applyStimulus(1'b0, 1'b1, 16'h00FF, 1'b1, 1'b0);
    checkOutput("pushPopCount", 32'(fifoCount), 32'd8);
    checkOutput("pushPopDrops", 32'(dropCount), 32'd1);
    for (int i = 2; i <= 9; i++) begin
      word = (i == 9) ? 16'h00FF : 16'(i);
      checkOutput("drainData", 32'(consumerData), 32'(word));
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end
    checkOutput("drainEmpty", 32'(consumerValid), 32'd0);

    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("clearFlag",  32'(overflowFlag), 32'd0);
    checkOutput("clearDrops", 32'(dropCount), 32'd0);

    // 5: stream 20 words with ready every other cycle; the strobe pauses only
    // when the FIFO is full and no pop is happening, so nothing is dropped.
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 20; cyc++) begin
      rdyNow = (cyc % 2 == 1);
      popNow = rdyNow && (model.size() > 0);
      enNow  = (sent < 20) && ((model.size() < 8) || popNow);
      word   = 16'h0100 + 16'(sent);
      checkOutput("wrapValid", 32'(consumerValid), 32'(model.size() > 0));
      if (popNow) begin
        checkOutput("wrapData", 32'(consumerData), 32'(model.pop_front()));
        got++;
      end
      if (enNow) begin
        model.push_back(int'(word));
        sent++;
      end
      applyStimulus(1'b0, enNow, word, rdyNow, 1'b0);
      checkOutput("wrapCount", 32'(fifoCount), 32'(model.size()));
      checkOutput("wrapBound", 32'(fifoCount <= 4'd8), 32'd1);
    end
    checkOutput("wrapReceived", 32'(got), 32'd20);
    checkOutput("wrapNoDrops",  32'(dropCount), 32'd0);

    // 6: fill, then 300 drops saturate the counter at 255.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b0);
    end
    checkOutput("satDrops", 32'(dropCount), 32'd255);
    checkOutput("satFlag",  32'(overflowFlag), 32'd1);
    checkOutput("satCount", 32'(fifoCount), 32'd8);
    checkOutput("satHead",  32'(consumerData), 32'h0200);
    applyStimulus(1'b0, 1'b1, 16'hDEAD, 1'b0, 1'b1);
    checkOutput("clrDropFlag",  32'(overflowFlag), 32'd1);
    checkOutput("clrDropDrops", 32'(dropCount), 32'd1);
    applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    checkOutput("clrOnlyFlag",  32'(overflowFlag), 32'd0);
    checkOutput("clrOnlyDrops", 32'(dropCount), 32'd0);

    // 7: drain to five entries, then reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    end
    checkOutput("midCount", 32'(fifoCount), 32'd5);
    checkOutput("midHead",  32'(consumerData), 32'h0203);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 1'b1, 1'b0);
    checkResetState("midReset");

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
